// File: rtl/edge_pkg.sv
// edge_pkg: shared types, pixel constants and threshold helper for the edge binarizer.
package edge_pkg;

   localparam int unsigned PIX_W = 24;
   localparam int unsigned S_W   = 8;

   localparam logic [PIX_W-1:0] PIX_EDGE = 24'hFFFFFF;
   localparam logic [PIX_W-1:0] PIX_BG   = 24'h000000;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      COUNT      = 2'd1,
      UPDATE     = 2'd2
   } stats_state_e;

   // Step the threshold up or down by one step, saturating at bound; sums are 9-bit so nothing wraps.
   function automatic logic [S_W-1:0] thr_step_clamp(input logic [S_W-1:0] thr,
                                                      input logic [S_W-1:0] step,
                                                      input logic [S_W-1:0] bound,
                                                      input logic           raise);
      if (raise)
         thr_step_clamp = (({1'b0, thr} + {1'b0, step}) > {1'b0, bound}) ? bound : thr + step;
      else
         thr_step_clamp = ({1'b0, thr} < ({1'b0, bound} + {1'b0, step})) ? bound : thr - step;
   endfunction

endpackage

// File: rtl/edge_frame_stats.sv
// edge_frame_stats: frame FSM, saturating edge counter and once-per-frame threshold adaptation.
module edge_frame_stats
   import edge_pkg::*;
#(
   parameter int unsigned THR_INIT  = 40,
   parameter int unsigned THR_MIN   = 8,
   parameter int unsigned THR_MAX   = 120,
   parameter int unsigned THR_STEP  = 4,
   parameter int unsigned CNT_W     = 22,
   parameter int unsigned TARGET_LO = 20000,
   parameter int unsigned TARGET_HI = 60000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boundary,
   input  logic             edge_bit,
   input  logic             adapt_en,
   output logic [S_W-1:0]   thr,
   output logic [CNT_W-1:0] edge_count,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stats_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] edge_count_q, edge_count_d;
   logic [S_W-1:0]   thr_q, thr_d;
   logic             frame_done_q, frame_done_d;

   // Next state: the boundary pixel is parked in pend and joins the new frame during UPDATE.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      edge_count_d = edge_count_q;
      thr_d        = thr_q;
      frame_done_d = 1'b0;
      case (state_q)
         WAIT_FRAME: begin
            if (boundary) begin
               state_d = COUNT;
               cnt_d   = CNT_W'(edge_bit);
            end
         end
         COUNT: begin
            if (boundary) begin
               state_d = UPDATE;
               pend_d  = edge_bit;
            end else if (edge_bit && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         UPDATE: begin
            state_d      = COUNT;
            edge_count_d = cnt_q;
            frame_done_d = 1'b1;
            cnt_d        = CNT_W'(pend_q) + CNT_W'(edge_bit);
            if (adapt_en) begin
               if (32'(cnt_q) > TARGET_HI)
                  thr_d = thr_step_clamp(thr_q, S_W'(THR_STEP), S_W'(THR_MAX), 1'b1);
               else if (32'(cnt_q) < TARGET_LO)
                  thr_d = thr_step_clamp(thr_q, S_W'(THR_STEP), S_W'(THR_MIN), 1'b0);
            end
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   // State and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_FRAME;
         cnt_q        <= '0;
         pend_q       <= 1'b0;
         edge_count_q <= '0;
         thr_q        <= S_W'(THR_INIT);
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         edge_count_q <= edge_count_d;
         thr_q        <= thr_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign thr        = thr_q;
   assign edge_count = edge_count_q;
   assign frame_done = frame_done_q;

endmodule

// File: rtl/edge_binarize.sv
// edge_binarize: 2-stage gradient threshold pipeline producing black/white edge pixels.
// Optional horizontal hysteresis is enabled by defining EDGE_HYST_EN.
module edge_binarize
   import edge_pkg::*;
#(
   parameter int unsigned THR_INIT  = 40,
   parameter int unsigned THR_MIN   = 8,
   parameter int unsigned THR_MAX   = 120,
   parameter int unsigned THR_STEP  = 4,
   parameter int unsigned CNT_W     = 22,
   parameter int unsigned TARGET_LO = 20000,
   parameter int unsigned TARGET_HI = 60000,
   parameter int unsigned VS_POL    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             de_in,
   input  logic             h_sync_in,
   input  logic             v_sync_in,
   input  logic             adapt_en,
   output logic             de_out,
   output logic             h_sync_out,
   output logic             v_sync_out,
   output logic [PIX_W-1:0] pixel_out,
   output logic [S_W-1:0]   thr_out,
   output logic [CNT_W-1:0] edge_count,
   output logic             frame_done
);

   localparam logic VS_ACT = 1'(VS_POL);

   logic [S_W-1:0]   s_s1_q, s_s1_d;
   logic             de_s1_q, de_s1_d;
   logic             hs_s1_q, hs_s1_d;
   logic             vs_s1_q, vs_s1_d;
   logic             vs_prev_q, vs_prev_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic             de_q, de_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic [S_W-1:0]   thr;
   logic             is_strong;
   logic             edge_bit;
   logic             boundary;
   logic             cbcr_unused;
`ifdef EDGE_HYST_EN
   logic             is_weak;
   logic             prev_edge_q, prev_edge_d;
`endif

   assign cbcr_unused = ^pixel_in[15:0];

   // Stage inputs, detect the active vsync edge and binarize the stage-1 magnitude.
   always_comb begin
      s_s1_d    = pixel_in[PIX_W-1 -: S_W];
      de_s1_d   = de_in;
      hs_s1_d   = h_sync_in;
      vs_s1_d   = v_sync_in;
      vs_prev_d = vs_s1_q;
      boundary  = (vs_s1_q == VS_ACT) && (vs_prev_q != VS_ACT);
      is_strong = (s_s1_q >= thr);
`ifdef EDGE_HYST_EN
      is_weak     = (s_s1_q >= (thr >> 1));
      edge_bit    = de_s1_q & (is_strong | (is_weak & prev_edge_q));
      prev_edge_d = edge_bit;
`else
      edge_bit    = de_s1_q & is_strong;
`endif
      pix_d = edge_bit ? PIX_EDGE : PIX_BG;
      de_d  = de_s1_q;
      hs_d  = hs_s1_q;
      vs_d  = vs_s1_q;
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_s1_q    <= '0;
         de_s1_q   <= 1'b0;
         hs_s1_q   <= 1'b0;
         vs_s1_q   <= 1'b0;
         vs_prev_q <= 1'b0;
         pix_q     <= PIX_BG;
         de_q      <= 1'b0;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
`ifdef EDGE_HYST_EN
         prev_edge_q <= 1'b0;
`endif
      end else begin
         s_s1_q    <= s_s1_d;
         de_s1_q   <= de_s1_d;
         hs_s1_q   <= hs_s1_d;
         vs_s1_q   <= vs_s1_d;
         vs_prev_q <= vs_prev_d;
         pix_q     <= pix_d;
         de_q      <= de_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
`ifdef EDGE_HYST_EN
         prev_edge_q <= prev_edge_d;
`endif
      end
   end

   edge_frame_stats #(
      .THR_INIT  (THR_INIT),
      .THR_MIN   (THR_MIN),
      .THR_MAX   (THR_MAX),
      .THR_STEP  (THR_STEP),
      .CNT_W     (CNT_W),
      .TARGET_LO (TARGET_LO),
      .TARGET_HI (TARGET_HI)
   ) u_stats (
      .clk        (clk),
      .rst        (rst),
      .boundary   (boundary),
      .edge_bit   (edge_bit),
      .adapt_en   (adapt_en),
      .thr        (thr),
      .edge_count (edge_count),
      .frame_done (frame_done)
   );

   assign pixel_out  = pix_q;
   assign de_out     = de_q;
   assign h_sync_out = hs_q;
   assign v_sync_out = vs_q;
   assign thr_out    = thr;

endmodule

// File: tb/tb_edge_binarize.sv
// tb_edge_binarize: directed and randomized checks of edge_binarize against a frame-level model.
`timescale 1ns/1ps
module tb_edge_binarize;

   // Scaled-down counter and targets keep whole frames short.
   localparam int unsigned CNT_W = 8;
   localparam int T_LO     = 20;
   localparam int T_HI     = 60;
   localparam int THR_INIT = 40;
   localparam int THR_MIN  = 8;
   localparam int THR_MAX  = 120;
   localparam int THR_STEP = 4;
   localparam int CNT_SAT  = (1 << CNT_W) - 1;

`ifdef EDGE_HYST_EN
   localparam logic [23:0] T1_SECOND = 24'hFFFFFF;
`else
   localparam logic [23:0] T1_SECOND = 24'h000000;
`endif
   localparam logic [7:0] HYS_S [5] = '{8'd50, 8'd25, 8'd25, 8'd10, 8'd25};
   localparam bit         HYS_E [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic             clk = 1'b0;
   logic             rst;
   logic [23:0]      pixel_in;
   logic             de_in, h_sync_in, v_sync_in, adapt_en;
   logic             de_out, h_sync_out, v_sync_out;
   logic [23:0]      pixel_out;
   logic [7:0]       thr_out;
   logic [CNT_W-1:0] edge_count;
   logic             frame_done;

   int vectors     = 0;
   int miscompares = 0;
   bit done        = 1'b0;

   always #5 clk = ~clk;

   edge_binarize #(.CNT_W(CNT_W), .TARGET_LO(T_LO), .TARGET_HI(T_HI)) dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .adapt_en(adapt_en),
      .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
      .pixel_out(pixel_out), .thr_out(thr_out), .edge_count(edge_count),
      .frame_done(frame_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: previous sample, frame accounting and the pending frame result.
   bit m_valid, m_counting, m_prev_edge, ev_pending, ed, bnd;
   int p_de, p_s, p_hs, p_vs, pp_vs, m_thr, m_cnt, ev_count;
   int e_pix, e_de, e_hs, e_vs, e_thr, e_cnt, e_done;

   // Model advances at each rising edge; outputs are compared at the following falling edge.
   initial begin
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         if (rst === 1'b1) begin
            p_de = 0; p_s = 0; p_hs = 0; p_vs = 0; pp_vs = 0;
            m_thr = THR_INIT; m_counting = 0; m_cnt = 0; m_prev_edge = 0;
            ev_pending = 0; ev_count = 0;
            e_pix = 0; e_de = 0; e_hs = 0; e_vs = 0; e_thr = THR_INIT; e_cnt = 0; e_done = 0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            ed = (p_de != 0) && (p_s >= m_thr);
`ifdef EDGE_HYST_EN
            ed = (p_de != 0) && ((p_s >= m_thr) || ((p_s >= m_thr / 2) && m_prev_edge));
            m_prev_edge = ed;
`endif
            bnd   = (p_vs != 0) && (pp_vs == 0);
            e_pix = ed ? 32'hFFFFFF : 0;
            e_de = p_de; e_hs = p_hs; e_vs = p_vs; e_done = 0;
            if (ev_pending) begin
               ev_pending = 0; e_done = 1; e_cnt = ev_count;
               if (adapt_en) begin
                  if (ev_count > T_HI)
                     m_thr = (m_thr + THR_STEP > THR_MAX) ? THR_MAX : m_thr + THR_STEP;
                  else if (ev_count < T_LO)
                     m_thr = (m_thr - THR_STEP < THR_MIN) ? THR_MIN : m_thr - THR_STEP;
               end
            end
            e_thr = m_thr;
            if (bnd) begin
               if (m_counting) begin
                  ev_pending = 1;
                  ev_count   = (m_cnt > CNT_SAT) ? CNT_SAT : m_cnt;
               end
               m_counting = 1;
               m_cnt = int'(ed);
            end else begin
               m_cnt += int'(ed);
            end
            pp_vs = p_vs;
            p_de = int'(de_in); p_s = int'(pixel_in[23:16]);
            p_hs = int'(h_sync_in); p_vs = int'(v_sync_in);
         end
         @(negedge clk);
         if (m_valid && !done) begin
            chk("pixel_out",  32'(pixel_out),  32'(e_pix));
            chk("de_out",     32'(de_out),     32'(e_de));
            chk("h_sync_out", 32'(h_sync_out), 32'(e_hs));
            chk("v_sync_out", 32'(v_sync_out), 32'(e_vs));
            chk("thr_out",    32'(thr_out),    32'(e_thr));
            chk("edge_count", 32'(edge_count), 32'(e_cnt));
            chk("frame_done", 32'(frame_done), 32'(e_done));
         end
      end
   end

   task automatic px(input logic de, input logic [7:0] s, input logic hs, input logic vs);
      @(negedge clk);
      de_in = de; pixel_in = {s, 16'($urandom)}; h_sync_in = hs; v_sync_in = vs;
   endtask

   task automatic line(input int n_edge, input int n_bg);
      for (int i = 0; i < n_edge + n_bg; i++) px(1'b1, (i < n_edge) ? 8'd255 : 8'd0, 1'b0, 1'b0);
      repeat (4) px(1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic frame_body(input int n_edge);
      int left;
      left = n_edge;
      if (left == 0) line(0, 40);
      while (left > 0) begin
         int k;
         k = (left > 30) ? 30 : left;
         line(k, 10);
         left -= k;
      end
   endtask

   // Drive a vsync pulse and capture any frame_done within a bounded window.
   task automatic vs_pulse(output bit seen, output int cnt, output int thr);
      seen = 0; cnt = -1; thr = -1;
      for (int i = 0; i < 8; i++) begin
         px(1'b0, 8'd0, 1'b0, 1'(i < 2));
         if (frame_done === 1'b1) begin
            seen = 1; cnt = int'(edge_count); thr = int'(thr_out);
         end
      end
   endtask

   initial begin
      bit seen;
      int c, t, n, nl, w;
      rst = 1'b1; pixel_in = '0; de_in = 0; h_sync_in = 0; v_sync_in = 0; adapt_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_pixel", 32'(pixel_out), 0);
      chk("rst_thr", 32'(thr_out), 40);
      chk("rst_done", 32'(frame_done), 0);
      rst = 1'b0;

      // Threshold compare at thr = 40, two-cycle latency on pixel and syncs.
      px(1'b1, 8'd40, 1'b1, 1'b0);
      px(1'b1, 8'd39, 1'b0, 1'b0);
      px(1'b0, 8'd0, 1'b0, 1'b0);
      chk("t1_edge", 32'(pixel_out), 32'hFFFFFF);
      chk("t1_de", 32'(de_out), 1);
      chk("t1_hs", 32'(h_sync_out), 1);
      px(1'b0, 8'd0, 1'b0, 1'b0);
      chk("t1_second", 32'(pixel_out), 32'(T1_SECOND));
      chk("t1_hs_low", 32'(h_sync_out), 0);
      px(1'b0, 8'd0, 1'b0, 1'b0);
      chk("t1_de_low", 32'(de_out), 0);

`ifdef EDGE_HYST_EN
      for (int i = 0; i < 7; i++) begin
         px(1'(i < 5), (i < 5) ? HYS_S[i] : 8'd0, 1'b0, 1'b0);
         if (i >= 2) chk("t5_hyst", 32'(pixel_out), HYS_E[i-2] ? 32'hFFFFFF : 0);
      end
      px(1'b1, 8'd25, 1'b0, 1'b0);
      px(1'b0, 8'd0, 1'b0, 1'b0);
      px(1'b0, 8'd0, 1'b0, 1'b0);
      chk("t5_line_start", 32'(pixel_out), 0);
`endif

      // Partial first frame is not reported.
      frame_body(70);
      vs_pulse(seen, c, t);
      chk("t4_no_done", 32'(seen), 0);
      chk("t4_thr", 32'(thr_out), 40);

      // Dense frame raises the threshold by one step.
      frame_body(100);
      vs_pulse(seen, c, t);
      chk("t2_done", 32'(seen), 1);
      chk("t2_count", 32'(c), 100);
      chk("t2_thr", 32'(t), 44);

      // Empty frames walk the threshold down to the floor.
      for (int i = 1; i <= 11; i++) begin
         frame_body(0);
         vs_pulse(seen, c, t);
         chk("t3_empty_cnt", 32'(c), 0);
         n = 44 - 4 * i;
         chk("t3_down_thr", 32'(t), 32'((n < 8) ? 8 : n));
      end
      chk("t3_floor", 32'(thr_out), 8);

      // Dense frames walk it up to the ceiling.
      for (int i = 1; i <= 30; i++) begin
         frame_body(100);
         vs_pulse(seen, c, t);
         n = 8 + 4 * i;
         chk("t3_up_thr", 32'(t), 32'((n > 120) ? 120 : n));
      end
      chk("t3_ceiling", 32'(thr_out), 120);

      // Counter saturation, then hold with adaptation disabled.
      frame_body(300);
      vs_pulse(seen, c, t);
      chk("sat_count", 32'(c), 255);
      adapt_en = 1'b0;
      frame_body(0);
      vs_pulse(seen, c, t);
      chk("hold_thr", 32'(t), 120);
      adapt_en = 1'b1;

      // Reset mid-frame.
      repeat (5) px(1'b1, 8'd255, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("t6_pixel", 32'(pixel_out), 0);
      chk("t6_thr", 32'(thr_out), 40);
      chk("t6_count", 32'(edge_count), 0);
      frame_body(50);
      vs_pulse(seen, c, t);
      chk("t6_first_bnd", 32'(seen), 0);
      frame_body(100);
      vs_pulse(seen, c, t);
      chk("t6_second_bnd", 32'(seen), 1);
      chk("t6_count2", 32'(c), 100);
      chk("t6_thr2", 32'(t), 44);

      // Randomized frames: random magnitudes, de gaps, sync widths, adapt toggles and resets.
      for (int f = 0; f < 30; f++) begin
         nl = $urandom_range(2, 5);
         for (int l = 0; l < nl; l++) begin
            w = $urandom_range(20, 50);
            for (int i = 0; i < w; i++) begin
               if ($urandom_range(0, 99) < 3) adapt_en = 1'($urandom_range(0, 1));
               px(1'($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            end
            n = $urandom_range(2, 6);
            repeat (n) px(1'b0, 8'($urandom), 1'b1, 1'b0);
         end
         n = $urandom_range(2, 4);
         for (int i = 0; i < n; i++)
            px(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         if ($urandom_range(0, 15) == 0) begin
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
         end
      end
      repeat (4) px(1'b0, 8'd0, 1'b0, 1'b0);

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
